hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline hazard scheduler for the 5-stage datapath.
- Detects load-use and branch-operand hazards in ID and sequences multi-cycle stalls with an internal FSM and counter.
- Drives the bubble select of the ID-stage control mux, PC and IF/ID write enables, and the IF/ID flush for taken branches and jumps.
- Keeps saturating stall and flush statistics counters.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, width of the statistics counters.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- ID_Rs  in  REG_W  source register 1 of the ID instruction.
- ID_Rt  in  REG_W  source register 2 of the ID instruction.
- ID_UsesRt  in  1  ID instruction reads Rt.
- ID_Branch  in  1  ID instruction is a conditional branch; compares in ID.
- ID_BranchTaken  in  1  branch comparison result; valid when ID_Branch=1.
- ID_Jump  in  1  ID instruction is a jump.
- EX_MemRead  in  1  EX instruction is a load.
- EX_RegWrite  in  1  EX instruction writes a register.
- EX_WriteReg  in  REG_W  EX destination register.
- MEM_MemRead  in  1  MEM instruction is a load.
- MEM_WriteReg  in  REG_W  MEM destination register.
- ExtStall  in  1  external multi-cycle stall request from a memory or SAD unit that is busy.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register write enable.
- CtrlMuxSel  out  1  1 = ID-stage control mux outputs zeros (bubble).
- IFIDFlush  out  1  clears IF/ID on the next edge.
- Stalling  out  1  FSM is in STALL or EXT.
- StallCycles  out  CNT_W  saturating count of stall cycles.
- FlushCount  out  CNT_W  saturating count of flushes.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - state=RUN, cnt=0, StallCycles=0, FlushCount=0.
  - Combinational outputs settle to PCWrite=1, IFIDWrite=1, CtrlMuxSel=0, IFIDFlush=0, Stalling=0.
- Register 0 never hazards: any match on specifier 0 is ignored.
- Hazard terms (combinational):
  - match(r) = (r!=0) & (r==ID_Rs | (ID_UsesRt & r==ID_Rt)).
  - LU: EX_MemRead & match(EX_WriteReg). Needs 1 stall; 2 if ID_Branch.
  - BR_EX: ID_Branch & EX_RegWrite & !EX_MemRead & match(EX_WriteReg). Needs 1 stall.
  - BR_MEM: ID_Branch & MEM_MemRead & match(MEM_WriteReg). Needs 1 stall.
  - need = max of the active terms, 0..2.
- Stall cycle outputs: PCWrite=0, IFIDWrite=0, CtrlMuxSel=1, IFIDFlush=0.
- FSM states: RUN, STALL, EXT.
- RUN:
  - If ExtStall: stall this cycle; next state EXT.
  - Else if need>0: stall this cycle (detection cycle counts as stall 1). If need=2, load cnt=1 and go to STALL; else stay in RUN.
  - Else no stall. If (ID_Branch & ID_BranchTaken) | ID_Jump: IFIDFlush=1 and FlushCount increments.
- STALL:
  - Stall outputs. cnt decrements each cycle; when cnt==0 at the edge, return to RUN.
  - Hazard inputs are ignored in STALL.
  - ExtStall while in STALL: finish the STALL, then go to EXT instead of RUN.
- EXT:
  - Stall outputs while ExtStall=1.
  - First cycle with ExtStall=0: the stall is still asserted. Next state RUN, where hazards are re-evaluated.
- Priority: stall beats flush. A taken branch whose operands are hazarded does not flush until the stall resolves.
- StallCycles increments on every edge where the stall outputs were asserted. Saturates at all-ones.
- Stalling=1 in STALL and EXT only. It is not asserted for a 1-cycle RUN stall.
- Reset asserted mid-stall: the FSM immediately returns to RUN, cnt=0, outputs take their reset values.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state encoding (RUN=2'd0, STALL=2'd1, EXT=2'd2);
  - REG_W;
  - the localparam stall depths: LU_STALL=1, LU_BR_STALL=2, BR_STALL=1.
- One sub-module, hazard_detect: purely combinational; produces need[1:0] from the register/ctrl inputs. The FSM, counters and output logic stay in the top module.

Test Plan:
- Load-use: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8, ID_Branch=0.
  - 1 cycle with PCWrite=0, CtrlMuxSel=1.
  - Next cycle PCWrite=1 once inputs advance.
  - StallCycles=1.
- Load then branch: EX_MemRead=1, EX_WriteReg=9, ID_Branch=1, ID_Rt=9, ID_UsesRt=1.
  - 2 stall cycles, Stalling=1 in the second.
  - Then EX inputs cleared, ID_BranchTaken=1 → IFIDFlush=1 for 1 cycle, FlushCount=1.
- Register-zero guard: EX_MemRead=1, EX_WriteReg=0, ID_Rs=0 → no stall, PCWrite=1 throughout.
- ExtStall held 4 cycles in RUN → 5 stall cycles (4 plus release cycle), then RUN; StallCycles=5.
- Jump with no hazard: ID_Jump=1 → IFIDFlush=1, CtrlMuxSel=0, PCWrite=1.
- Reset mid-stall: assert Rst_n=0 during the 2-cycle branch stall.
  - Outputs return to PCWrite=1, CtrlMuxSel=0 without waiting for a clock edge.
  - StallCycles=0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: state encoding,
// register-specifier width and the stall depth of each hazard class.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    localparam int unsigned LU_STALL    = 1;
    localparam int unsigned LU_BR_STALL = 2;
    localparam int unsigned BR_STALL    = 1;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StExt   = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detector: reports how many stall cycles the ID
// instruction needs (0..2) given the EX and MEM destination registers.
module hazard_detect #(
    parameter int unsigned REG_W = pipe_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_branch_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_reg_write_i,
    input  logic [REG_W-1:0] ex_write_reg_i,
    input  logic             mem_mem_read_i,
    input  logic [REG_W-1:0] mem_write_reg_i,
    output logic [1:0]       need_o
);
    import pipe_ctrl_pkg::*;

    logic       ex_match;
    logic       mem_match;
    logic [1:0] lu_need;
    logic [1:0] br_ex_need;
    logic [1:0] br_mem_need;

    // Register 0 is hardwired, so a write to it can never be a hazard.
    assign ex_match  = (ex_write_reg_i != '0) &&
                       ((ex_write_reg_i == id_rs_i) ||
                        (id_uses_rt_i && (ex_write_reg_i == id_rt_i)));
    assign mem_match = (mem_write_reg_i != '0) &&
                       ((mem_write_reg_i == id_rs_i) ||
                        (id_uses_rt_i && (mem_write_reg_i == id_rt_i)));

    always_comb begin
        lu_need     = 2'd0;
        br_ex_need  = 2'd0;
        br_mem_need = 2'd0;
        if (ex_mem_read_i && ex_match) begin
            lu_need = id_branch_i ? 2'(LU_BR_STALL) : 2'(LU_STALL);
        end
        if (id_branch_i && ex_reg_write_i && !ex_mem_read_i && ex_match) begin
            br_ex_need = 2'(BR_STALL);
        end
        if (id_branch_i && mem_mem_read_i && mem_match) begin
            br_mem_need = 2'(BR_STALL);
        end
    end

    always_comb begin
        need_o = lu_need;
        if (br_ex_need > need_o) begin
            need_o = br_ex_need;
        end
        if (br_mem_need > need_o) begin
            need_o = br_mem_need;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard scheduler: sequences load-use, branch-operand and external
// stalls, drives the IF/ID enables, bubble select and flush, and keeps statistics.
module hazard_stall_controller #(
    parameter int unsigned REG_W = pipe_ctrl_pkg::REG_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_BranchTaken,
    input  logic             ID_Jump,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [REG_W-1:0] EX_WriteReg,
    input  logic             MEM_MemRead,
    input  logic [REG_W-1:0] MEM_WriteReg,
    input  logic             ExtStall,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             CtrlMuxSel,
    output logic             IFIDFlush,
    output logic             Stalling,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);
    import pipe_ctrl_pkg::*;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             ext_pend_q, ext_pend_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic [1:0] need;
    logic       stall;
    logic       flush;
    logic       stalling;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .id_rs_i         (ID_Rs),
        .id_rt_i         (ID_Rt),
        .id_uses_rt_i    (ID_UsesRt),
        .id_branch_i     (ID_Branch),
        .ex_mem_read_i   (EX_MemRead),
        .ex_reg_write_i  (EX_RegWrite),
        .ex_write_reg_i  (EX_WriteReg),
        .mem_mem_read_i  (MEM_MemRead),
        .mem_write_reg_i (MEM_WriteReg),
        .need_o          (need)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ext_pend_d = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        stalling   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (ExtStall) begin
                    stall   = 1'b1;
                    state_d = StExt;
                end else if (need != 2'd0) begin
                    // The detection cycle is the first stall; STALL covers the rest.
                    stall = 1'b1;
                    if (need > 2'd1) begin
                        cnt_d   = need - 2'd1;
                        state_d = StStall;
                    end
                end else if ((ID_Branch && ID_BranchTaken) || ID_Jump) begin
                    flush = 1'b1;
                end
            end
            StStall: begin
                stall    = 1'b1;
                stalling = 1'b1;
                if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = (ext_pend_q || ExtStall) ? StExt : StRun;
                end else begin
                    cnt_d      = cnt_q - 2'd1;
                    ext_pend_d = ext_pend_q || ExtStall;
                end
            end
            StExt: begin
                // The release cycle (ExtStall low) still stalls.
                stall    = 1'b1;
                stalling = 1'b1;
                if (!ExtStall) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q        <= StRun;
            cnt_q          <= 2'd0;
            ext_pend_q     <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ext_pend_q     <= ext_pend_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    // Gate with reset so outputs take idle values while Rst_n is low,
    // even if the hazard inputs still show a conflict.
    assign PCWrite     = !(stall && Rst_n);
    assign IFIDWrite   = !(stall && Rst_n);
    assign CtrlMuxSel  = stall && Rst_n;
    assign IFIDFlush   = flush && Rst_n;
    assign Stalling    = stalling && Rst_n;
    assign StallCycles = stall_cycles_q;
    assign FlushCount  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: stimulus pushes expected
// responses from a cycle-level reference model; a negedge monitor compares.
module tb_hazard_stall_controller;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = 15;

    logic             Clk;
    logic             Rst_n;
    logic [REG_W-1:0] ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
    logic             ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
    logic             EX_MemRead, EX_RegWrite, MEM_MemRead, ExtStall;
    logic             PCWrite, IFIDWrite, CtrlMuxSel, IFIDFlush, Stalling;
    logic [CNT_W-1:0] StallCycles, FlushCount;

    hazard_stall_controller #(
        .REG_W (REG_W),
        .CNT_W (CNT_W)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .ID_Branch      (ID_Branch),
        .ID_BranchTaken (ID_BranchTaken),
        .ID_Jump        (ID_Jump),
        .EX_MemRead     (EX_MemRead),
        .EX_RegWrite    (EX_RegWrite),
        .EX_WriteReg    (EX_WriteReg),
        .MEM_MemRead    (MEM_MemRead),
        .MEM_WriteReg   (MEM_WriteReg),
        .ExtStall       (ExtStall),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .CtrlMuxSel     (CtrlMuxSel),
        .IFIDFlush      (IFIDFlush),
        .Stalling       (Stalling),
        .StallCycles    (StallCycles),
        .FlushCount     (FlushCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       pcw;
        logic       ifidw;
        logic       mux;
        logic       flush;
        logic       stalling;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: pending stall cycles, external-stall mode, statistics.
    int m_extra;
    bit m_in_ext;
    bit m_ext_after;
    int m_sc;
    int m_fc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit reg_hit(input logic [REG_W-1:0] r);
        return (r != 0) && ((r == ID_Rs) || (ID_UsesRt && (r == ID_Rt)));
    endfunction

    function automatic int need_of();
        int n;
        n = 0;
        if (EX_MemRead && reg_hit(EX_WriteReg)) n = ID_Branch ? 2 : 1;
        if (ID_Branch && EX_RegWrite && !EX_MemRead && reg_hit(EX_WriteReg) && n < 1) n = 1;
        if (ID_Branch && MEM_MemRead && reg_hit(MEM_WriteReg) && n < 1) n = 1;
        return n;
    endfunction

    task automatic model_reset();
        m_extra     = 0;
        m_in_ext    = 1'b0;
        m_ext_after = 1'b0;
        m_sc        = 0;
        m_fc        = 0;
    endtask

    task automatic model_step();
        bit   st, fl, stl;
        int   n;
        exp_t e;
        st  = 1'b0;
        fl  = 1'b0;
        stl = 1'b0;
        n   = need_of();
        if (m_in_ext) begin
            st  = 1'b1;
            stl = 1'b1;
            if (!ExtStall) m_in_ext = 1'b0;
        end else if (m_extra > 0) begin
            st  = 1'b1;
            stl = 1'b1;
            m_extra--;
            if (ExtStall) m_ext_after = 1'b1;
            if (m_extra == 0) begin
                m_in_ext    = m_ext_after;
                m_ext_after = 1'b0;
            end
        end else if (ExtStall) begin
            st       = 1'b1;
            m_in_ext = 1'b1;
        end else if (n > 0) begin
            st      = 1'b1;
            m_extra = n - 1;
        end else if ((ID_Branch && ID_BranchTaken) || ID_Jump) begin
            fl = 1'b1;
        end
        e.pcw      = !st;
        e.ifidw    = !st;
        e.mux      = st;
        e.flush    = fl;
        e.stalling = stl;
        e.sc       = 4'(m_sc);
        e.fc       = 4'(m_fc);
        exp_q.push_back(e);
        if (st && m_sc < CMAX) m_sc++;
        if (fl && m_fc < CMAX) m_fc++;
    endtask

    task automatic set_idle();
        ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0; ID_Branch = 1'b0;
        ID_BranchTaken = 1'b0; ID_Jump = 1'b0; EX_MemRead = 1'b0;
        EX_RegWrite = 1'b0; EX_WriteReg = '0; MEM_MemRead = 1'b0;
        MEM_WriteReg = '0; ExtStall = 1'b0;
    endtask

    // One cycle: inputs change just after the rising edge, then the expected
    // response for that cycle is queued.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                         input logic br, input logic tk, input logic jp,
                         input logic exmr, input logic exrw, input logic [4:0] exwr,
                         input logic memmr, input logic [4:0] memwr, input logic ext);
        @(posedge Clk);
        #1;
        ID_Rs = rs; ID_Rt = rt; ID_UsesRt = ut; ID_Branch = br; ID_BranchTaken = tk;
        ID_Jump = jp; EX_MemRead = exmr; EX_RegWrite = exrw; EX_WriteReg = exwr;
        MEM_MemRead = memmr; MEM_WriteReg = memwr; ExtStall = ext;
        model_step();
    endtask

    task automatic idle_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (Rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("PCWrite", 32'(PCWrite), 32'(e.pcw));
            chk("IFIDWrite", 32'(IFIDWrite), 32'(e.ifidw));
            chk("CtrlMuxSel", 32'(CtrlMuxSel), 32'(e.mux));
            chk("IFIDFlush", 32'(IFIDFlush), 32'(e.flush));
            chk("Stalling", 32'(Stalling), 32'(e.stalling));
            chk("StallCycles", 32'(StallCycles), 32'(e.sc));
            chk("FlushCount", 32'(FlushCount), 32'(e.fc));
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_PCWrite"}, 32'(PCWrite), 32'd1);
        chk({tag, "_IFIDWrite"}, 32'(IFIDWrite), 32'd1);
        chk({tag, "_CtrlMuxSel"}, 32'(CtrlMuxSel), 32'd0);
        chk({tag, "_IFIDFlush"}, 32'(IFIDFlush), 32'd0);
        chk({tag, "_Stalling"}, 32'(Stalling), 32'd0);
        chk({tag, "_StallCycles"}, 32'(StallCycles), 32'd0);
        chk({tag, "_FlushCount"}, 32'(FlushCount), 32'd0);
    endtask

    initial begin
        int ext_left;
        logic [4:0] rs, rt, exwr, memwr;
        logic ext;
        Rst_n = 1'b1;
        set_idle();
        model_reset();
        #1;
        Rst_n = 1'b0;
        // Load-use hazard present while in reset: outputs must still be idle.
        ID_Rs = 5'd8; EX_MemRead = 1'b1; EX_WriteReg = 5'd8;
        #3;
        check_reset_outputs("reset");
        set_idle();
        @(posedge Clk);
        #2;
        Rst_n = 1'b1;

        // Load-use: one stall, then released.
        drive(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
        idle_cycle();
        // Load then branch on Rt: two stalls, then the taken branch flushes.
        drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
        drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
        drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        idle_cycle();
        // Register zero never hazards.
        drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        // Branch operand produced by ALU op in EX, then by a load in MEM.
        drive(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
        drive(5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
        idle_cycle();
        // External stall held four cycles, then released.
        repeat (4) drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        idle_cycle();
        idle_cycle();
        // Jump with no hazard.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        // External stall arriving during a 2-cycle branch stall.
        drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0);
        drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1);
        drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

        ext_left = 0;
        for (int i = 0; i < 1500; i++) begin
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            exwr  = 5'($urandom_range(0, 3));
            memwr = 5'($urandom_range(0, 3));
            ext   = 1'b0;
            if (ext_left > 0) begin
                ext = 1'b1;
                ext_left--;
            end else if ($urandom_range(0, 19) == 0) begin
                ext      = 1'b1;
                ext_left = $urandom_range(0, 4);
            end
            drive(rs, rt, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                  1'($urandom), 1'($urandom), exwr, 1'($urandom), memwr, ext);
        end
        idle_cycle();
        idle_cycle();

        // Reset asserted in the second cycle of a load-then-branch stall.
        drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
        drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
        @(negedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        set_idle();
        model_reset();
        @(posedge Clk);
        #2;
        Rst_n = 1'b1;
        drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
        idle_cycle();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge Clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left unchecked", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
